vmem_wr_sched: RTL

- Schedules writes into the single-port 24-bit frame memory (address {h[9:0], v[8:0]}, 19 bits) alongside the VGA scan-out reader.
- The reader owns the memory port whenever the display is active (vga_valid=1). Writes are issued only during blanking.
- Sources: a buffered pixel-write stream (valid/ready) and a clear-screen sweep FSM.
- Sits between pixel producers (PS/2 text engine, LFSR pattern fill) and the vmem write port.

---
 rtl/vmem_wr_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vmem_wr_sched.sv
// Frame-memory write scheduler: arbitrates a buffered pixel-write FIFO and a clear-screen sweep
// into the vmem port during blanking. Define VMEM_WR_CNT_EN to add the saturating wr_cnt output.
module vmem_wr_sched #(
  parameter int H_MAX      = 640,
  parameter int V_MAX      = 480,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vga_valid,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [9:0]                    wr_h,
  input  logic [8:0]                    wr_v,
  input  logic [23:0]                   wr_data,
  input  logic                          clr_req,
  input  logic [23:0]                   clr_color,
  output logic                          clr_busy,
  output logic                          clr_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          mem_we,
  output logic [18:0]                   mem_addr,
  output logic [23:0]                   mem_wdata
`ifdef VMEM_WR_CNT_EN
  ,
  output logic [15:0]                   wr_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [9:0] H_LAST = 10'(H_MAX - 1);
  localparam logic [8:0] V_LAST = 9'(V_MAX - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  typedef struct packed {
    logic [9:0]  h;
    logic [8:0]  v;
    logic [23:0] data;
  } pix_t;

  pix_t            fifo_mem [FIFO_DEPTH];
  pix_t            head;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            full, empty, push, pop;

  state_e          state_q, state_d;
  logic [9:0]      h_q, h_d;
  logic [8:0]      v_q, v_d;
  logic [23:0]     color_q, color_d;
  logic            done_q, done_d;

  assign full       = (level_q == LW'(FIFO_DEPTH));
  assign empty      = (level_q == '0);
  assign wr_ready   = ~full;
  assign push       = wr_valid & ~full;
  assign head       = fifo_mem[rd_ptr_q];
  assign fifo_level = level_q;
  assign clr_busy   = (state_q == S_CLEAR);
  assign clr_done   = done_q;

  // NOTE: the storage array has no reset; the pointers and level alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{h: wr_h, v: wr_v, data: wr_data};
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    color_d   = color_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (!vga_valid && !empty) begin
          mem_we    = 1'b1;
          mem_addr  = {head.h, head.v};
          mem_wdata = head.data;
          pop       = 1'b1;
        end
        if (clr_req) begin
          state_d = S_CLEAR;
          color_d = clr_color;
          h_d     = '0;
          v_d     = '0;
        end
      end
      S_CLEAR: begin
        if (!vga_valid) begin
          mem_we    = 1'b1;
          mem_addr  = {h_q, v_q};
          mem_wdata = color_q;
          if (v_q == V_LAST) begin
            v_d = '0;
            if (h_q == H_LAST) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              h_d = h_q + 1'b1;
            end
          end else begin
            v_d = v_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= S_IDLE;
      h_q      <= '0;
      v_q      <= '0;
      color_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      h_q      <= h_d;
      v_q      <= v_d;
      color_q  <= color_d;
      done_q   <= done_d;
    end
  end

`ifdef VMEM_WR_CNT_EN
  logic [15:0] wr_cnt_q;
  assign wr_cnt = wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                                wr_cnt_q <= '0;
    else if (mem_we && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
  end
`endif

endmodule
